// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported, multi-cycle SRAM between the instruction-fetch
// port (rom_*) and the data-access port (ram_*). A data access always goes
// first, then the fetch. The core is stalled until both have completed.
//
// Parameters:
//   WAIT_CYCLES  SRAM cycles per access (>= 1)
//   ADDR_W       SRAM word-address width (byte address bits [ADDR_W+1:2])
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rom_ce_i/addr_i     fetch request / byte address
//   rom_data_o          fetched instruction (registered)
//   ram_ce_i/we_i/sel_i data request / store flag / byte enables
//   ram_addr_i/data_i   data byte address / store data
//   ram_data_o          load data (registered)
//   hold_i              pipeline held by another stall source
//   stallreq_o          stall request to ctrl
//   sram_*              SRAM control, address, write data, read data
//
// Optional feature: define MEM_ARB_INST_BUF_EN to add a one-entry fetch
// buffer that lets a repeated fetch of the same word skip the SRAM access.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              ram_ce_i,
    input  logic              ram_we_i,
    input  logic [3:0]        ram_sel_i,
    input  logic [31:0]       ram_addr_i,
    input  logic [31:0]       ram_data_i,
    output logic [31:0]       ram_data_o,
    input  logic              hold_i,
    output logic              stallreq_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [3:0]        sram_be_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DACC, S_IACC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         rom_data_q, rom_data_d;
    logic [31:0]         ram_data_q, ram_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [ADDR_W-1:0]   rom_word;
    logic [ADDR_W-1:0]   ram_word;

    assign rom_word = rom_addr_i[ADDR_W+1:2];
    assign ram_word = ram_addr_i[ADDR_W+1:2];

    // Only the word-address bits are used; the rest are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr_i, ram_addr_i};

`ifdef MEM_ARB_INST_BUF_EN
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              buf_hit;
    logic              store_kills_buf;

    assign buf_hit         = buf_vld_q && (buf_tag_q == rom_word);
    // A store in the same round must win over a stale buffered copy.
    assign store_kills_buf = ram_ce_i && ram_we_i && (ram_word == buf_tag_q);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rom_data_d   = rom_data_q;
        ram_data_d   = ram_data_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sram_ce_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = 4'b0000;
        sram_addr_o  = addr_q;
        sram_wdata_o = wdata_q;
`ifdef MEM_ARB_INST_BUF_EN
        buf_vld_d    = buf_vld_q;
        buf_tag_d    = buf_tag_q;
        buf_data_d   = buf_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ram_ce_i) begin
                    state_d = S_DACC;
                    cnt_d   = CNT_LOAD;
                end else if (rom_ce_i) begin
`ifdef MEM_ARB_INST_BUF_EN
                    if (buf_hit) begin
                        rom_data_d = buf_data_q;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_IACC;
                        cnt_d   = CNT_LOAD;
                    end
`else
                    state_d = S_IACC;
                    cnt_d   = CNT_LOAD;
`endif
                end
            end
            S_DACC: begin
                sram_ce_o    = 1'b1;
                sram_we_o    = ram_we_i;
                sram_be_o    = ram_sel_i;
                sram_addr_o  = ram_word;
                sram_wdata_o = ram_data_i;
                addr_d       = ram_word;
                wdata_d      = ram_data_i;
`ifdef MEM_ARB_INST_BUF_EN
                if (store_kills_buf) begin
                    buf_vld_d = 1'b0;
                end
`endif
                if (cnt_q == '0) begin
                    if (!ram_we_i) begin
                        ram_data_d = sram_rdata_i;
                    end
                    if (rom_ce_i) begin
`ifdef MEM_ARB_INST_BUF_EN
                        if (buf_hit && !store_kills_buf) begin
                            rom_data_d = buf_data_q;
                            state_d    = S_DONE;
                        end else begin
                            state_d = S_IACC;
                            cnt_d   = CNT_LOAD;
                        end
`else
                        state_d = S_IACC;
                        cnt_d   = CNT_LOAD;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IACC: begin
                sram_ce_o   = 1'b1;
                sram_be_o   = 4'b1111;
                sram_addr_o = rom_word;
                addr_d      = rom_word;
                if (cnt_q == '0) begin
                    rom_data_d = sram_rdata_i;
                    state_d    = S_DONE;
`ifdef MEM_ARB_INST_BUF_EN
                    buf_vld_d  = 1'b1;
                    buf_tag_d  = rom_word;
                    buf_data_d = sram_rdata_i;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!hold_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rom_data_q <= '0;
            ram_data_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef MEM_ARB_INST_BUF_EN
            buf_vld_q  <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_data_q <= rom_data_d;
            ram_data_q <= ram_data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef MEM_ARB_INST_BUF_EN
            buf_vld_q  <= buf_vld_d;
            buf_tag_q  <= buf_tag_d;
            buf_data_q <= buf_data_d;
`endif
        end
    end

    assign rom_data_o = rom_data_q;
    assign ram_data_o = ram_data_q;
    assign stallreq_o = (rom_ce_i || ram_ce_i) && (state_q != S_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int W  = 2;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          rom_ce = 0, ram_ce = 0, ram_we = 0, hold = 0;
    logic [31:0]   rom_addr = 0, ram_addr = 0, ram_wdata = 0;
    logic [3:0]    ram_sel = 0;
    logic [31:0]   rom_data, ram_data, sram_wdata, sram_rdata;
    logic          stallreq, sram_ce, sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;

    mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data),
        .ram_ce_i(ram_ce), .ram_we_i(ram_we), .ram_sel_i(ram_sel),
        .ram_addr_i(ram_addr), .ram_data_i(ram_wdata), .ram_data_o(ram_data),
        .hold_i(hold), .stallreq_o(stallreq),
        .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_be_o(sram_be),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    // Second instance exercising the single-cycle access boundary (fetch only).
    logic          rom_ce1 = 0;
    logic [31:0]   rom_data1, ram_data1, sram_wdata1, sram_rdata1;
    logic          stall1, sram_ce1, sram_we1;
    logic [3:0]    sram_be1;
    logic [AW-1:0] sram_addr1;

    mem_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce1), .rom_addr_i(32'h0000_0104), .rom_data_o(rom_data1),
        .ram_ce_i(1'b0), .ram_we_i(1'b0), .ram_sel_i(4'b0000),
        .ram_addr_i(32'h0), .ram_data_i(32'h0), .ram_data_o(ram_data1),
        .hold_i(1'b0), .stallreq_o(stall1),
        .sram_ce_o(sram_ce1), .sram_we_o(sram_we1), .sram_be_o(sram_be1),
        .sram_addr_o(sram_addr1), .sram_wdata_o(sram_wdata1), .sram_rdata_i(sram_rdata1)
    );

    // SRAM environment (written by the DUT) and reference memory (model).
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        mem[10'h40] = 32'h2401_0005; ref_mem[10'h40] = 32'h2401_0005;
        mem[10'h41] = 32'h8C22_0000; ref_mem[10'h41] = 32'h8C22_0000;
        mem[10'h80] = 32'hDEAD_BEEF; ref_mem[10'h80] = 32'hDEAD_BEEF;
        mem[10'hC0] = 32'h1122_3344; ref_mem[10'hC0] = 32'h1122_3344;
    end

    assign sram_rdata  = mem[sram_addr[9:0]];
    assign sram_rdata1 = mem[sram_addr1[9:0]];

    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            for (int b = 0; b < 4; b++)
                if (sram_be[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model state.
    logic          active = 0;
    int            k = 0, D = 0, t_n = 0;
    logic          t_ram, t_we, t_fetch;
    logic [3:0]    t_sel;
    logic [AW-1:0] t_rword, t_fword;
    logic [31:0]   t_wd;
    logic [31:0]   cur_ram = 0, cur_rom = 0, new_ram = 0, new_rom = 0;
    logic [AW-1:0] last_addr = 0;
    logic [31:0]   last_wd = 0;
    logic          m_bvld = 0;
    logic [AW-1:0] m_btag = 0;
    int            ce_cycles = 0, we_cycles = 0;

    always @(negedge clk) begin
        if (sram_ce) ce_cycles++;
        if (sram_we) we_cycles++;
    end

    // Per-cycle compare against the transaction schedule.
    always @(negedge clk) begin
        if (active) begin
            if (k == D) begin
                cur_ram = new_ram;
                cur_rom = new_rom;
                if (t_n > 0) last_addr = t_fetch ? t_fword : t_rword;
                if (t_ram) last_wd = t_wd;
            end
            if (k == 0 || k >= D) begin
                chk("stallreq", 32'(stallreq), (k < D) ? 32'd1 : 32'd0);
                chk("sram_ce_idle", 32'(sram_ce), 32'd0);
                chk("sram_we_idle", 32'(sram_we), 32'd0);
                chk("sram_be_idle", 32'(sram_be), 32'd0);
                chk("sram_addr_hold", 32'(sram_addr), 32'(last_addr));
                chk("sram_wdata_hold", sram_wdata, last_wd);
                chk("ram_data", ram_data, cur_ram);
                chk("rom_data", rom_data, cur_rom);
            end else begin
                automatic bit is_data = t_ram && ((k - 1) / W == 0);
                chk("stallreq_acc", 32'(stallreq), 32'd1);
                chk("sram_ce_acc", 32'(sram_ce), 32'd1);
                chk("sram_we_acc", 32'(sram_we), is_data ? 32'(t_we) : 32'd0);
                chk("sram_be_acc", 32'(sram_be), is_data ? 32'(t_sel) : 32'hF);
                chk("sram_addr_acc", 32'(sram_addr), is_data ? 32'(t_rword) : 32'(t_fword));
                if (is_data) chk("sram_wdata_acc", sram_wdata, t_wd);
            end
            k++;
        end
    end

    task automatic txn(input logic rc, input logic we, input logic [3:0] sel,
                       input logic [31:0] ra, input logic [31:0] wd,
                       input logic fc, input logic [31:0] fa, input int h);
        logic hit;
        t_ram = rc; t_we = we; t_sel = sel; t_wd = wd;
        t_rword = ra[AW+1:2];
        t_fword = fa[AW+1:2];
        hit = 1'b0;
`ifdef MEM_ARB_INST_BUF_EN
        if (rc && we && t_rword == m_btag) m_bvld = 1'b0;
        hit = fc && m_bvld && (m_btag == t_fword);
`endif
        t_fetch = fc && !hit;
        t_n = int'(rc) + int'(t_fetch);
        D = 1 + W * t_n;
        new_ram = cur_ram;
        new_rom = cur_rom;
        if (rc) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[t_rword[9:0]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                new_ram = ref_mem[t_rword[9:0]];
            end
        end
        if (fc) new_rom = ref_mem[t_fword[9:0]];
`ifdef MEM_ARB_INST_BUF_EN
        if (t_fetch) begin m_bvld = 1'b1; m_btag = t_fword; end
`endif
        ram_ce = rc; ram_we = we; ram_sel = sel; ram_addr = ra; ram_wdata = wd;
        rom_ce = fc; rom_addr = fa; hold = (h > 0);
        k = 0;
        active = 1'b1;
        repeat (D + h) @(posedge clk);
        #1 hold = 1'b0;
        @(posedge clk);
        #1 ram_ce = 1'b0; rom_ce = 1'b0; ram_we = 1'b0;
        active = 1'b0;
    endtask

    initial begin
        int n, c0, w0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_sram_ce", 32'(sram_ce), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_rom_data", rom_data, 32'd0);
        chk("rst_ram_data", ram_data, 32'd0);
        rom_ce = 1'b1;
        #1 chk("rst_stallreq_req", 32'(stallreq), 32'd1);
        rom_ce = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-cycle access instance: fetch stalls exactly 2 cycles
        rom_ce1 = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stall1) n++;
            else break;
        end
        chk("w1_stall_cycles", 32'(n), 32'd2);
        chk("w1_rom_data", rom_data1, 32'h8C22_0000);
        @(posedge clk);
        #1 rom_ce1 = 1'b0;

        // Fetch only
        txn(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0000_0100, 0);
        chk("lit_fetch_100", rom_data, 32'h2401_0005);
        // Load plus fetch
        c0 = ce_cycles;
        txn(1, 0, 4'hF, 32'h0000_0200, 32'h0, 1, 32'h0000_0104, 0);
        chk("lit_load_200", ram_data, 32'hDEAD_BEEF);
        chk("lit_fetch_104", rom_data, 32'h8C22_0000);
        chk("lit_load_fetch_ce_cycles", 32'(ce_cycles - c0), 32'd4);
        // Half-word store
        w0 = we_cycles;
        txn(1, 1, 4'b0011, 32'h0000_0300, 32'h0000_ABCD, 0, 32'h0, 0);
        chk("lit_store_we_cycles", 32'(we_cycles - w0), 32'd2);
        chk("lit_store_keeps_ram_data", ram_data, 32'hDEAD_BEEF);
        txn(1, 0, 4'hF, 32'h0000_0300, 32'h0, 0, 32'h0, 0);
        chk("lit_load_300", ram_data, 32'h1122_ABCD);
        // Upper-half store and read back
        txn(1, 1, 4'b1100, 32'h0000_030C, 32'h7766_5544, 0, 32'h0, 0);
        txn(1, 0, 4'hF, 32'h0000_030C, 32'h0, 0, 32'h0, 0);
        chk("lit_load_30c", ram_data, 32'h7766_00C3);
        // Hold for 3 cycles in DONE
        c0 = ce_cycles;
        txn(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0000_0104, 3);
        chk("lit_hold_ce_cycles", 32'(ce_cycles - c0), 32'd2);
        // Store and fetch to the same word in one round
        txn(1, 1, 4'hF, 32'h0000_0108, 32'h0BAD_F00D, 1, 32'h0000_0108, 0);
        chk("lit_store_then_fetch", rom_data, 32'h0BAD_F00D);
        // Repeated fetch, then store to it and fetch again
        txn(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0000_0100, 0);
        c0 = ce_cycles;
        txn(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0000_0100, 0);
`ifdef MEM_ARB_INST_BUF_EN
        chk("lit_buf_hit_no_access", 32'(ce_cycles - c0), 32'd0);
`else
        chk("lit_refetch_access", 32'(ce_cycles - c0), 32'd2);
`endif
        chk("lit_refetch_data", rom_data, 32'h2401_0005);
        txn(1, 1, 4'hF, 32'h0000_0100, 32'h2402_000A, 0, 32'h0, 0);
        c0 = ce_cycles;
        txn(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0000_0100, 0);
        chk("lit_fetch_after_store_access", 32'(ce_cycles - c0), 32'd2);
        chk("lit_fetch_after_store", rom_data, 32'h2402_000A);

        // Reset in the second cycle of a store
        ram_ce = 1'b1; ram_we = 1'b1; ram_sel = 4'hF;
        ram_addr = 32'h0000_0500; ram_wdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_store_we", 32'(sram_we), 32'd1);
        rst = 1'b1; ram_ce = 1'b0; ram_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[10'h140] = 32'h55AA_55AA;
        chk("rst_mid_stallreq", 32'(stallreq), 32'd0);
        chk("rst_mid_sram_we", 32'(sram_we), 32'd0);
        chk("rst_mid_sram_ce", 32'(sram_ce), 32'd0);
        chk("rst_mid_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_mid_sram_wdata", sram_wdata, 32'd0);
        chk("rst_mid_rom_data", rom_data, 32'd0);
        chk("rst_mid_ram_data", ram_data, 32'd0);
        cur_ram = 0; cur_rom = 0; last_addr = 0; last_wd = 0; m_bvld = 1'b0;
        // Recovery fetch after reset must access the SRAM again
        c0 = ce_cycles;
        txn(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0000_0100, 0);
        chk("lit_post_rst_access", 32'(ce_cycles - c0), 32'd2);
        chk("lit_post_rst_fetch", rom_data, 32'h2402_000A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
